// File: rtl/lifo_pkg.sv
// lifo_pkg: shared depth/count-width helpers and the push/pop operation decode for the LIFO stack
package lifo_pkg;
    typedef enum logic [1:0] {OP_IDLE, OP_PUSH, OP_POP, OP_SWAP} op_e;
    function automatic int depth_of(input int pointer_width);
        return 1 << pointer_width;
    endfunction
    function automatic int cnt_width(input int pointer_width);
        return pointer_width + 1;
    endfunction
endpackage

// File: rtl/lifo_status_flags.sv
// lifo_status_flags: occupancy, threshold and sticky error status; error counters built only with LIFO_ERR_CNT_EN
module lifo_status_flags
    import lifo_pkg::*;
#(
    parameter int POINTER_WIDTH = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [POINTER_WIDTH:0] pointer,
    input  op_e                    op,
    input  logic [POINTER_WIDTH:0] low_th_level,
    input  logic [POINTER_WIDTH:0] high_th_level,
    input  logic                   clr_err,
    output logic                   lifo_empty,
    output logic                   lifo_full,
    output logic                   lifo_low_th,
    output logic                   lifo_high_th,
    output logic                   lifo_ov,
    output logic                   lifo_ud,
    output logic [CNT_WIDTH-1:0]   ov_cnt,
    output logic [CNT_WIDTH-1:0]   ud_cnt
);
    localparam int CW = cnt_width(POINTER_WIDTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(depth_of(POINTER_WIDTH));
    logic ov_ev, ud_ev;
    always_comb begin
        lifo_empty   = pointer == '0;
        lifo_full    = pointer == FULL_LVL;
        lifo_low_th  = pointer <= low_th_level;
        lifo_high_th = pointer >= high_th_level;
        ov_ev        = op == OP_PUSH && lifo_full;
        ud_ev        = (op == OP_POP || op == OP_SWAP) && lifo_empty;
    end
    // a new error in the clr_err cycle wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            lifo_ov <= 1'b0;
            lifo_ud <= 1'b0;
        end else begin
            lifo_ov <= ov_ev || (lifo_ov && !clr_err);
            lifo_ud <= ud_ev || (lifo_ud && !clr_err);
        end
    end
`ifdef LIFO_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_cnt <= '0;
            ud_cnt <= '0;
        end else begin
            ov_cnt <= clr_err ? CNT_WIDTH'(ov_ev) : ov_cnt + CNT_WIDTH'(ov_ev && ov_cnt != '1);
            ud_cnt <= clr_err ? CNT_WIDTH'(ud_ev) : ud_cnt + CNT_WIDTH'(ud_ev && ud_cnt != '1);
        end
    end
`else
    assign ov_cnt = '0;
    assign ud_cnt = '0;
`endif
endmodule

// File: rtl/lifo_stack_status.sv
// lifo_stack_status: LIFO stack with integrated status flags; LIFO_ERR_CNT_EN enables saturating error counters
module lifo_stack_status
    import lifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int POINTER_WIDTH = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [POINTER_WIDTH:0] low_th_level,
    input  logic [POINTER_WIDTH:0] high_th_level,
    input  logic                   clr_err,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic [POINTER_WIDTH:0] pointer,
    output logic                   lifo_empty,
    output logic                   lifo_full,
    output logic                   lifo_low_th,
    output logic                   lifo_high_th,
    output logic                   lifo_ov,
    output logic                   lifo_ud,
    output logic [CNT_WIDTH-1:0]   ov_cnt,
    output logic [CNT_WIDTH-1:0]   ud_cnt
);
    localparam int DEPTH = depth_of(POINTER_WIDTH);
    localparam int CW = cnt_width(POINTER_WIDTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    op_e op;
    logic inc, dec, pop_ok, do_wr;
    logic [POINTER_WIDTH-1:0] top_idx, wr_idx;
    // a swap on a non-empty stack overwrites the top entry in place
    always_comb begin
        op      = wr && rd ? OP_SWAP : wr ? OP_PUSH : rd ? OP_POP : OP_IDLE;
        inc     = (op == OP_PUSH && !lifo_full) || (op == OP_SWAP && lifo_empty);
        dec     = op == OP_POP && !lifo_empty;
        pop_ok  = (op == OP_POP || op == OP_SWAP) && !lifo_empty;
        do_wr   = (op == OP_PUSH && !lifo_full) || op == OP_SWAP;
        top_idx = pointer[POINTER_WIDTH-1:0] - 1'b1;
        wr_idx  = op == OP_SWAP && !lifo_empty ? top_idx : pointer[POINTER_WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (!rst && do_wr) mem[wr_idx] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pointer  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            pointer  <= pointer + CW'(inc) - CW'(dec);
            rd_valid <= pop_ok;
            if (pop_ok) rd_data <= mem[top_idx];
        end
    end
    lifo_status_flags #(
        .POINTER_WIDTH(POINTER_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_flags (
        .clk(clk),
        .rst(rst),
        .pointer(pointer),
        .op(op),
        .low_th_level(low_th_level),
        .high_th_level(high_th_level),
        .clr_err(clr_err),
        .lifo_empty(lifo_empty),
        .lifo_full(lifo_full),
        .lifo_low_th(lifo_low_th),
        .lifo_high_th(lifo_high_th),
        .lifo_ov(lifo_ov),
        .lifo_ud(lifo_ud),
        .ov_cnt(ov_cnt),
        .ud_cnt(ud_cnt)
    );
endmodule

// File: tb/tb_lifo_stack_status.sv
// tb_lifo_stack_status: scoreboard-driven checks of push/pop/swap, thresholds, sticky flags and counters
module tb_lifo_stack_status;
    logic clk = 1'b0, rst = 1'b1, wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [15:0] wr_data = '0;
    logic [4:0] low_th_level = 5'd3, high_th_level = 5'd8;
    logic [15:0] rd_data;
    logic rd_valid, lifo_empty, lifo_full, lifo_low_th, lifo_high_th, lifo_ov, lifo_ud;
    logic [4:0] pointer;
    logic [7:0] ov_cnt, ud_cnt;
    int checks = 0, failures = 0;
    logic [15:0] model[$];
    logic [15:0] exp_q[$];
    logic [15:0] exp_d;
`ifdef LIFO_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    lifo_stack_status dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .wr_data(wr_data),
        .low_th_level(low_th_level), .high_th_level(high_th_level), .clr_err(clr_err),
        .rd_data(rd_data), .rd_valid(rd_valid), .pointer(pointer),
        .lifo_empty(lifo_empty), .lifo_full(lifo_full), .lifo_low_th(lifo_low_th),
        .lifo_high_th(lifo_high_th), .lifo_ov(lifo_ov), .lifo_ud(lifo_ud),
        .ov_cnt(ov_cnt), .ud_cnt(ud_cnt)
    );

    always #5 clk = ~clk;

    // drives one cycle, updates the reference stack and queues expected pop data
    task automatic cycle(input logic w, input logic r, input logic [15:0] d);
        int n;
        n = model.size();
        if (w && r && n > 0) begin
            exp_q.push_back(model[n-1]);
            model[n-1] = d;
        end else if (w && r) model.push_back(d);
        else if (w && n < 16) model.push_back(d);
        else if (r && n > 0) exp_q.push_back(model.pop_back());
        wr = w; rd = r; wr_data = d;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        low_th_level = 5'd3; high_th_level = 5'd8;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pointer !== 5'd0) begin failures++; $display("FAIL reset_pointer got=%0d exp=0", pointer); end
        checks++; if (rd_data !== 16'h0 || rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd got=%h/%b exp=0000/0", rd_data, rd_valid); end
        checks++; if ({lifo_empty, lifo_full, lifo_low_th, lifo_high_th} !== 4'b1010) begin failures++; $display("FAIL reset_status got=%b exp=1010", {lifo_empty, lifo_full, lifo_low_th, lifo_high_th}); end
        checks++; if ({lifo_ov, lifo_ud} !== 2'b00 || ov_cnt !== 8'd0 || ud_cnt !== 8'd0) begin failures++; $display("FAIL reset_err got=%b %0d %0d exp=00 0 0", {lifo_ov, lifo_ud}, ov_cnt, ud_cnt); end
        high_th_level = 5'd0; #1;
        checks++; if (lifo_high_th !== 1'b1) begin failures++; $display("FAIL reset_high0 got=%b exp=1", lifo_high_th); end
        high_th_level = 5'd8;
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 16'(i));
        checks++; if (pointer !== 5'd16 || lifo_full !== 1'b1 || lifo_high_th !== 1'b1 || lifo_ov !== 1'b0) begin failures++; $display("FAIL fill got=%0d full=%b hi=%b ov=%b exp=16 1 1 0", pointer, lifo_full, lifo_high_th, lifo_ov); end
        cycle(1'b1, 1'b0, 16'hDEAD);
        checks++; if (pointer !== 5'd16 || lifo_ov !== 1'b1) begin failures++; $display("FAIL overflow got=%0d ov=%b exp=16 1", pointer, lifo_ov); end
        checks++; if (ov_cnt !== 8'(CNT_EN)) begin failures++; $display("FAIL ov_cnt got=%0d exp=%0d", ov_cnt, CNT_EN); end
        cycle(1'b0, 1'b1, 16'h0);
        exp_d = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp_d || rd_data !== 16'h0010) begin failures++; $display("FAIL pop_after_ov got=%h/%b exp=%h/1", rd_data, rd_valid, exp_d); end
    endtask

    task automatic test_underflow_clear();
        do_reset();
        cycle(1'b0, 1'b1, 16'h0);
        checks++; if (rd_valid !== 1'b0 || lifo_ud !== 1'b1 || rd_data !== 16'h0) begin failures++; $display("FAIL underflow got=%b ud=%b d=%h exp=0 1 0000", rd_valid, lifo_ud, rd_data); end
        checks++; if (ud_cnt !== 8'(CNT_EN)) begin failures++; $display("FAIL ud_cnt got=%0d exp=%0d", ud_cnt, CNT_EN); end
        cycle(1'b0, 1'b1, 16'h0);
        clr_err = 1'b1;
        cycle(1'b0, 1'b0, 16'h0);
        checks++; if (lifo_ud !== 1'b0 || ud_cnt !== 8'd0) begin failures++; $display("FAIL clr_err got=%b %0d exp=0 0", lifo_ud, ud_cnt); end
        cycle(1'b0, 1'b1, 16'h0);
        cycle(1'b0, 1'b1, 16'h0);
        clr_err = 1'b1;
        cycle(1'b0, 1'b1, 16'h0);
        checks++; if (lifo_ud !== 1'b1 || ud_cnt !== 8'(CNT_EN)) begin failures++; $display("FAIL clr_set_wins got=%b %0d exp=1 %0d", lifo_ud, ud_cnt, CNT_EN); end
        cycle(1'b1, 1'b1, 16'h1234);
        checks++; if (pointer !== 5'd1 || rd_valid !== 1'b0 || lifo_ud !== 1'b1 || ud_cnt !== 8'(2 * CNT_EN)) begin failures++; $display("FAIL swap_empty got=%0d v=%b ud=%b c=%0d exp=1 0 1 %0d", pointer, rd_valid, lifo_ud, ud_cnt, 2 * CNT_EN); end
    endtask

    task automatic test_swap();
        do_reset();
        cycle(1'b1, 1'b0, 16'hAAAA);
        cycle(1'b1, 1'b0, 16'hBBBB);
        cycle(1'b1, 1'b1, 16'hCCCC);
        exp_d = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
        checks++; if (rd_data !== exp_d || rd_valid !== 1'b1 || pointer !== 5'd2 || exp_d !== 16'hBBBB) begin failures++; $display("FAIL swap got=%h/%b/%0d exp=%h/1/2", rd_data, rd_valid, pointer, exp_d); end
        checks++; if ({lifo_ov, lifo_ud} !== 2'b00) begin failures++; $display("FAIL swap_err got=%b exp=00", {lifo_ov, lifo_ud}); end
        cycle(1'b0, 1'b1, 16'h0);
        exp_d = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
        checks++; if (rd_data !== exp_d || rd_valid !== 1'b1 || exp_d !== 16'hCCCC) begin failures++; $display("FAIL pop_after_swap got=%h/%b exp=%h/1", rd_data, rd_valid, exp_d); end
        cycle(1'b0, 1'b0, 16'h0);
        checks++; if (rd_valid !== 1'b0 || rd_data !== 16'hCCCC) begin failures++; $display("FAIL rd_valid_pulse got=%b/%h exp=0/cccc", rd_valid, rd_data); end
    endtask

    task automatic test_thresholds();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'(i + 16'h100));
        checks++; if (pointer !== 5'd3 || lifo_low_th !== 1'b1) begin failures++; $display("FAIL low_th_at3 got=%0d/%b exp=3/1", pointer, lifo_low_th); end
        cycle(1'b1, 1'b0, 16'h0103);
        checks++; if (pointer !== 5'd4 || lifo_low_th !== 1'b0) begin failures++; $display("FAIL low_th_at4 got=%0d/%b exp=4/0", pointer, lifo_low_th); end
        high_th_level = 5'd4; #1;
        checks++; if (lifo_high_th !== 1'b1) begin failures++; $display("FAIL high_th_eq got=%b exp=1", lifo_high_th); end
        high_th_level = 5'd17; low_th_level = 5'd31; #1;
        checks++; if (lifo_high_th !== 1'b0 || lifo_low_th !== 1'b1) begin failures++; $display("FAIL th_above_depth got=%b/%b exp=0/1", lifo_high_th, lifo_low_th); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'($urandom_range(0, 65535)));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 16'h0);
            exp_d = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin failures++; $display("FAIL b2b_pop%0d got=%h/%b exp=%h/1", i, rd_data, rd_valid, exp_d); end
        end
        checks++; if (pointer !== 5'd0 || lifo_empty !== 1'b1 || lifo_ud !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0d/%b/%b exp=0/1/0", pointer, lifo_empty, lifo_ud); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 16'(i));
        for (int i = 0; i < 260; i++) cycle(1'b1, 1'b0, 16'hEEEE);
        checks++; if (ov_cnt !== 8'(CNT_EN ? 255 : 0) || pointer !== 5'd16) begin failures++; $display("FAIL ov_saturate got=%0d/%0d exp=%0d/16", ov_cnt, pointer, CNT_EN ? 255 : 0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b0, 1'b1, 16'h0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'(i));
        checks++; if (pointer !== 5'd5 || lifo_ud !== 1'b1) begin failures++; $display("FAIL pre_reset got=%0d/%b exp=5/1", pointer, lifo_ud); end
        rst = 1'b1; wr = 1'b1; wr_data = 16'h5555;
        @(posedge clk); #1;
        rst = 1'b0; wr = 1'b0;
        model.delete(); exp_q.delete();
        checks++; if (pointer !== 5'd0 || lifo_empty !== 1'b1 || rd_valid !== 1'b0 || {lifo_ov, lifo_ud} !== 2'b00 || ud_cnt !== 8'd0) begin failures++; $display("FAIL reset_mid got=%0d/%b/%b/%b/%0d exp=0/1/0/00/0", pointer, lifo_empty, rd_valid, {lifo_ov, lifo_ud}, ud_cnt); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_underflow_clear();
        test_swap();
        test_thresholds();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lifo_stack_status.md
# lifo_stack_status

Parametrised LIFO stack with integrated status generation: storage, stack pointer, empty/full, programmable low/high threshold flags and sticky overflow/underflow flags in one block. It replaces the standalone status-signal LIFO logic, which depended on external empty/full and pointer inputs. It sits between a producer and a consumer on the security datapath. Thresholds are runtime-programmable, and simultaneous push/pop replaces the top entry.

## Interface
- DATA_WIDTH, 16, entry width in bits
- POINTER_WIDTH, 4, address width; DEPTH = 2**POINTER_WIDTH entries
- CNT_WIDTH, 8, width of error event counters
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  reset, synchronous, active-high
- wr  input  1  push request
- rd  input  1  pop request
- wr_data  input  DATA_WIDTH  data to push
- low_th_level  input  POINTER_WIDTH+1  low threshold (count compare)
- high_th_level  input  POINTER_WIDTH+1  high threshold (count compare)
- clr_err  input  1  clears lifo_ov, lifo_ud and error counters
- rd_data  output  DATA_WIDTH  popped data, registered
- rd_valid  output  1  rd_data valid this cycle
- pointer  output  POINTER_WIDTH+1  current occupancy count, 0..DEPTH
- lifo_empty, lifo_full  output  1 each  count==0 / count==DEPTH
- lifo_low_th, lifo_high_th  output  1 each  count<=low_th_level / count>=high_th_level
- lifo_ov, lifo_ud  output  1 each  sticky overflow / underflow
- ov_cnt, ud_cnt  output  CNT_WIDTH each  saturating error event counts

## Operation
- Reset values: pointer=0, rd_data=0, rd_valid=0, lifo_ov=0, lifo_ud=0, ov_cnt=0, ud_cnt=0. Derived outputs follow: lifo_empty=1, lifo_full=0, lifo_low_th=1, lifo_high_th=(high_th_level==0). Memory contents are not reset.
- Push only, not full: mem[pointer]<=wr_data, pointer+1.
- Push only, full: write dropped, pointer unchanged, lifo_ov set.
- Pop only, not empty: rd_data<=mem[pointer-1], rd_valid=1, pointer-1.
- Pop only, empty: rd_valid=0, rd_data held, lifo_ud set.
- Push+pop, not empty (including full): rd_data<=old mem[pointer-1] and mem[pointer-1]<=wr_data in the same edge. pointer unchanged, rd_valid=1, no ov/ud.
- Push+pop, empty: push performed (pointer 0→1), pop flagged as underflow, rd_valid=0.
- Sticky flags: set on offending edge, held until clr_err. If clr_err and a new error coincide, the set wins and the counter becomes 1.
- Threshold compares are unsigned on POINTER_WIDTH+1 bits and combinational from registered pointer. Levels above DEPTH simply never/always match. No glitch-filtering.

## Timing
- Status outputs reflect pointer after the edge; no added latency.
- Pop latency: rd_data/rd_valid valid in the cycle after rd is sampled; rd_valid is a single-cycle pulse per accepted pop.
- lifo_ov/lifo_ud assert the cycle after the offending request.
- Reset mid-operation: the next edge with rst=1 forces reset values regardless of wr/rd/clr_err.
- Back-to-back pops each cycle are supported at full rate.

## Configuration
- LIFO_ERR_CNT_EN defined: ov_cnt/ud_cnt increment once per offending cycle, saturate at 2**CNT_WIDTH-1, and clear on clr_err or rst.
- LIFO_ERR_CNT_EN undefined: counter registers are not built, ov_cnt/ud_cnt are tied to 0, and sticky flags are unaffected.

## Structure
- Shared package lifo_pkg holds: DEPTH derivation function, the count type width (POINTER_WIDTH+1), and the op-decode enum {OP_IDLE, OP_PUSH, OP_POP, OP_SWAP}.
- One sub-module, lifo_status_flags, takes pointer, wr/rd accept decode, thresholds and clr_err. It produces empty/full/threshold/sticky/counter outputs. Storage and pointer stay in the top.

## Test plan
- Reset then 16 pushes 0x0001..0x0010 (DEPTH 16) → pointer=16, lifo_full=1, lifo_high_th=1 with high_th_level=8, lifo_ov=0.
- 17th push 0xDEAD → pointer stays 16, lifo_ov=1 next cycle, ov_cnt=1 (macro on); then pop returns 0x0010, not 0xDEAD.
- Pop from empty after reset → rd_valid=0, lifo_ud=1, ud_cnt=1. Then clr_err → lifo_ud=0, ud_cnt=0.
- Push 0xAAAA, 0xBBBB, then push+pop 0xCCCC → rd_data=0xBBBB, rd_valid=1, pointer=2. Next pop → 0xCCCC.
- low_th_level=3: pushes take pointer 3→4 → lifo_low_th falls on the edge where pointer becomes 4.
- Assert rst while pointer=5 and wr=1 → next cycle pointer=0, lifo_empty=1, rd_valid=0, flags cleared.
